game_round_ctrl: RTL and testbench

Round scheduler for the LED memory game core. It owns the level counter, lives, difficulty and pacing. It drives the core's active-low-reset `enable` once per round, generates the difficulty-scaled pace tick that paces the light sequence, and converts the core's pass/fail pulses and player inactivity into level, difficulty and lives updates. It sits between the board-level start switch and the game core.

---
 rtl/game_round_ctrl_if.sv | 25 ++
 rtl/game_round_ctrl.sv | 145 ++++++++++++++
 tb/tb_game_round_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/game_round_ctrl_if.sv
// Round-control bundle between the start switch, the game core and the scheduler.
// The scheduler takes the slave side and the board/core side takes the master side.
interface game_round_ctrl_if;
  logic       start;
  logic       core_good;
  logic       core_fail;
  logic       sw_activity;
  logic       core_enable;
  logic       pace_tick;
  logic [2:0] difficulty;
  logic [3:0] level;
  logic [1:0] lives;
  logic       game_over;
  logic       win;

  modport master (
    output start, core_good, core_fail, sw_activity,
    input  core_enable, pace_tick, difficulty, level, lives, game_over, win
  );

  modport slave (
    input  start, core_good, core_fail, sw_activity,
    output core_enable, pace_tick, difficulty, level, lives, game_over, win
  );
endinterface

// File: rtl/game_round_ctrl.sv
// Round scheduler for the LED memory game: level/lives/difficulty, core restart and pace tick.
// Result pulses land two edges later in the counters; inputs are pulses with no backpressure.
module game_round_ctrl #(
  parameter int TICK_BASE     = 1000,
  parameter int DIFF_MAX      = 7,
  parameter int LIVES         = 3,
  parameter int LEVEL_MAX     = 10,
  parameter int TIMEOUT_TICKS = 16
) (
  input logic               clk,
  input logic               rst,
  game_round_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_PLAY = 3'd2,
    S_PASS = 3'd3,
    S_MISS = 3'd4,
    S_OVER = 3'd5
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [15:0] pace_cnt_q;
  logic [15:0] period;
  logic [7:0]  to_cnt_q;
  logic [2:0]  diff_q;
  logic [3:0]  level_q;
  logic [1:0]  lives_q;
  logic        win_q;
  logic        tick;
  logic        timeout;
  logic        enable;
  logic        over;

  // Period only depends on difficulty, which is frozen for the whole PLAY visit.
  assign period  = 16'(TICK_BASE) * (16'd8 - 16'(diff_q));
  assign tick    = (state_q == S_PLAY) && (pace_cnt_q == period - 16'd1);
  assign timeout = (to_cnt_q >= 8'(TIMEOUT_TICKS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) state_d = S_ARM;
      end
      S_ARM: state_d = S_PLAY;
      S_PLAY: begin
        if (bus.core_fail || timeout) state_d = S_MISS;
        else if (bus.core_good)       state_d = S_PASS;
      end
      S_PASS: state_d = (level_q == 4'(LEVEL_MAX)) ? S_OVER : S_ARM;
      S_MISS: state_d = (lives_q <= 2'd1) ? S_OVER : S_ARM;
      default: state_d = S_IDLE;
    endcase
  end

  // The core stays enabled through PASS/MISS so each round drops enable only in ARM.
  always_comb begin
    enable = 1'b0;
    over   = 1'b0;
    case (state_q)
      S_PLAY, S_PASS, S_MISS: enable = 1'b1;
      S_OVER:                 over   = 1'b1;
      default: begin
        enable = 1'b0;
        over   = 1'b0;
      end
    endcase
  end

  assign bus.core_enable = enable;
  assign bus.game_over   = over;
  assign bus.pace_tick   = tick;
  assign bus.difficulty  = diff_q;
  assign bus.level       = level_q;
  assign bus.lives       = lives_q;
  assign bus.win         = win_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pace_cnt_q <= 16'd0;
      to_cnt_q   <= 8'd0;
    end else if (state_q == S_ARM) begin
      pace_cnt_q <= 16'd0;
      to_cnt_q   <= 8'd0;
    end else if (state_q == S_PLAY) begin
      pace_cnt_q <= tick ? 16'd0 : pace_cnt_q + 16'd1;
      // Player activity beats a simultaneous tick.
      if (bus.sw_activity) begin
        to_cnt_q <= 8'd0;
      end else if (tick) begin
        to_cnt_q <= to_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q  <= 3'd0;
      level_q <= 4'd0;
      lives_q <= 2'd0;
      win_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (bus.start) begin
            diff_q  <= 3'd0;
            level_q <= 4'd1;
            lives_q <= 2'(LIVES);
            win_q   <= 1'b0;
          end
        end
        S_PASS: begin
          diff_q <= (diff_q >= 3'(DIFF_MAX)) ? 3'(DIFF_MAX) : diff_q + 3'd1;
          if (level_q == 4'(LEVEL_MAX)) begin
            win_q <= 1'b1;
          end else begin
            level_q <= level_q + 4'd1;
          end
        end
        S_MISS: begin
          diff_q  <= (diff_q == 3'd0) ? 3'd0 : diff_q - 3'd1;
          lives_q <= (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end
        default: begin
          diff_q  <= diff_q;
          level_q <= level_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with TICK_BASE=4, LIVES=3, LEVEL_MAX=10, TIMEOUT_TICKS=2.
module tb_game_round_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  game_round_ctrl_if bus();

  game_round_ctrl #(
    .TICK_BASE(4),
    .DIFF_MAX(7),
    .LIVES(3),
    .LEVEL_MAX(10),
    .TIMEOUT_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic s, g, f, a;
    logic ce, tk;
    int   d, l, lv;
    logic go, w;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic ce, input logic tk, input int d,
                         input int l, input int lv, input logic go, input logic w);
    chk({tag, ".core_enable"}, int'(bus.core_enable), int'(ce));
    chk({tag, ".pace_tick"},   int'(bus.pace_tick),   int'(tk));
    chk({tag, ".difficulty"},  int'(bus.difficulty),  d);
    chk({tag, ".level"},       int'(bus.level),       l);
    chk({tag, ".lives"},       int'(bus.lives),       lv);
    chk({tag, ".game_over"},   int'(bus.game_over),   int'(go));
    chk({tag, ".win"},         int'(bus.win),         int'(w));
  endtask

  task automatic drive(input logic s, input logic g, input logic f, input logic a);
    bus.start       = s;
    bus.core_good   = g;
    bus.core_fail   = f;
    bus.sw_activity = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].s, tbl[i].g, tbl[i].f, tbl[i].a);
      step();
      chk_out($sformatf("row%0d", i), tbl[i].ce, tbl[i].tk, tbl[i].d, tbl[i].l,
              tbl[i].lv, tbl[i].go, tbl[i].w);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Steps until pace_tick is seen; compares the number of edges taken.
  task automatic wait_tick(input logic act, input int exp, input string name);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    bus.sw_activity = act;
    while (!seen && n < 200) begin
      step();
      n++;
      seen = bus.pace_tick;
    end
    bus.sw_activity = 1'b0;
    chk(name, seen ? n : -1, exp);
  endtask

  task automatic do_round(input logic g, input logic f, input bit to_over, input string tag);
    bus.core_good = g;
    bus.core_fail = f;
    step();
    bus.core_good = 1'b0;
    bus.core_fail = 1'b0;
    chk({tag, ".result_ce"}, int'(bus.core_enable), 1);
    step();
    if (to_over) begin
      chk({tag, ".over"}, int'(bus.game_over), 1);
    end else begin
      chk({tag, ".arm_ce"}, int'(bus.core_enable), 0);
      step();
      chk({tag, ".play_ce"}, int'(bus.core_enable), 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    //          s  g  f  a   ce tk  d  L  lv  go w
    tbl[0]  = '{1, 0, 0, 0,  0, 0,  0, 1, 3,  0, 0};
    tbl[1]  = '{0, 0, 0, 0,  1, 0,  0, 1, 3,  0, 0};
    tbl[2]  = '{0, 1, 0, 0,  1, 0,  0, 1, 3,  0, 0};
    tbl[3]  = '{0, 0, 0, 0,  0, 0,  1, 2, 3,  0, 0};
    tbl[4]  = '{0, 0, 0, 0,  1, 0,  1, 2, 3,  0, 0};
    tbl[5]  = '{0, 1, 0, 0,  1, 0,  1, 2, 3,  0, 0};
    tbl[6]  = '{0, 0, 0, 0,  0, 0,  2, 3, 3,  0, 0};
    tbl[7]  = '{0, 0, 0, 0,  1, 0,  2, 3, 3,  0, 0};
    tbl[8]  = '{0, 1, 1, 0,  1, 0,  2, 3, 3,  0, 0};
    tbl[9]  = '{0, 0, 0, 0,  0, 0,  1, 3, 2,  0, 0};
    tbl[10] = '{0, 0, 0, 0,  1, 0,  1, 3, 2,  0, 0};
    tbl[11] = '{0, 0, 1, 0,  1, 0,  1, 3, 2,  0, 0};
    tbl[12] = '{0, 1, 0, 0,  0, 0,  0, 3, 1,  0, 0};
    tbl[13] = '{0, 0, 1, 0,  1, 0,  0, 3, 1,  0, 0};
    tbl[14] = '{0, 0, 0, 1,  1, 0,  0, 3, 1,  0, 0};

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("reset", 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk_out("idle", 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Start, two passes, then measure the difficulty-2 pace period.
    run_rows(0, 7);
    wait_tick(1'b1, 23, "first_tick_d2");
    wait_tick(1'b1, 24, "tick_gap_d2");

    // good+fail together, then a fail with pulses ignored in MISS/ARM.
    run_rows(8, 14);

    // Activity coincident with the first tick defers the timeout by one tick.
    wait_tick(1'b0, 30, "tick_before_act");
    bus.sw_activity = 1'b1;
    step();
    bus.sw_activity = 1'b0;
    chk("act_on_tick.ce", int'(bus.core_enable), 1);
    wait_tick(1'b0, 31, "tick_after_act");
    chk("no_miss_yet", int'(bus.game_over), 0);
    wait_tick(1'b0, 32, "second_idle_tick");
    step();
    chk("timeout_play.ce", int'(bus.core_enable), 1);
    chk("timeout_play.go", int'(bus.game_over), 0);
    step();
    chk("timeout_miss.go", int'(bus.game_over), 0);
    step();
    chk_out("timeout_over", 1'b0, 1'b0, 0, 3, 0, 1'b1, 1'b0);

    // Fresh game from OVER, base period, then three consecutive fails.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_out("restart_arm", 1'b0, 1'b0, 0, 1, 3, 1'b0, 1'b0);
    step();
    chk("restart_play.ce", int'(bus.core_enable), 1);
    wait_tick(1'b1, 31, "first_tick_d0");
    wait_tick(1'b1, 32, "tick_gap_d0");
    do_round(1'b0, 1'b1, 1'b0, "fail1");
    chk("fail1.lives", int'(bus.lives), 2);
    do_round(1'b0, 1'b1, 1'b0, "fail2");
    chk("fail2.lives", int'(bus.lives), 1);
    do_round(1'b0, 1'b1, 1'b1, "fail3");
    chk_out("lost", 1'b0, 1'b0, 0, 1, 0, 1'b1, 1'b0);

    // Ten passes with start held high throughout: PLAY ignores it, OVER restarts on it.
    bus.start = 1'b1;
    step();
    chk_out("win_arm", 1'b0, 1'b0, 0, 1, 3, 1'b0, 1'b0);
    step();
    chk("win_play.ce", int'(bus.core_enable), 1);
    for (int i = 1; i <= 10; i++) begin
      do_round(1'b1, 1'b0, (i == 10), $sformatf("pass%0d", i));
      chk($sformatf("pass%0d.level", i), int'(bus.level), (i < 10) ? i + 1 : 10);
      chk($sformatf("pass%0d.diff", i), int'(bus.difficulty), (i < 7) ? i : 7);
    end
    chk_out("won", 1'b0, 1'b0, 7, 10, 3, 1'b1, 1'b1);
    step();
    chk_out("held_start_arm", 1'b0, 1'b0, 0, 1, 3, 1'b0, 1'b0);
    bus.start = 1'b0;
    step();
    step();
    step();
    chk_out("pre_rst_play", 1'b1, 1'b0, 0, 1, 3, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a cycle.
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk_out("post_rst_idle", 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
